// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the processor-facing memory responder.
// Used by sys_mem_resp and burst_tracker.
package mem_resp_pkg;

  localparam int DATA_W        = 16;
  localparam int DEF_BURST_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } memState_t;

endpackage

// File: rtl/sys_mem_resp_burst_tracker.sv
// Tracks runs of consecutive same-type, address-sequential accesses.
// Pulses BurstDone when a run reaches BURST_LEN.
module burst_tracker
  import mem_resp_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic        Hold,
  input  logic        Access,
  input  memState_t   AccType,
  input  logic [15:0] Addr,
  output logic        BurstDone
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [CNT_W-1:0] burstCnt;
  logic [CNT_W-1:0] burstCntNext;
  logic [15:0]      prevAddr;
  logic [15:0]      prevAddrNext;
  memState_t        prevType;
  memState_t        prevTypeNext;
  logic             doneNext;
  logic [31:0]      seqLen;

  // Next run length; the 16-bit compare makes FFFF->0000 count as sequential.
  always_comb begin
    burstCntNext = burstCnt;
    prevAddrNext = prevAddr;
    prevTypeNext = prevType;
    doneNext     = 1'b0;
    seqLen       = 32'd0;
    if (Hold) begin
      burstCntNext = burstCnt;
    end else if (Access) begin
      if ((prevType == AccType) && (Addr == prevAddr + 16'd1)) begin
        seqLen = 32'(burstCnt) + 32'd1;
      end else begin
        seqLen = 32'd1;
      end
      if (seqLen == 32'(BURST_LEN)) begin
        burstCntNext = '0;
        doneNext     = 1'b1;
      end else begin
        burstCntNext = seqLen[CNT_W-1:0];
      end
      prevAddrNext = Addr;
      prevTypeNext = AccType;
    end else begin
      burstCntNext = '0;
      prevTypeNext = IDLE;
    end
  end

  // Run state and the registered BurstDone pulse.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      burstCnt  <= '0;
      prevAddr  <= 16'd0;
      prevType  <= IDLE;
      BurstDone <= 1'b0;
    end else begin
      burstCnt  <= burstCntNext;
      prevAddr  <= prevAddrNext;
      prevType  <= prevTypeNext;
      BurstDone <= doneNext;
    end
  end

endmodule

// File: rtl/sys_mem_resp.sv
// Word-addressed memory responder with preload port, error pulses and access counters.
// Optional write-protect window enabled by defining MEM_WRPROT_EN.
module sys_mem_resp
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              Clk1,
  input  logic              Reset,
  input  logic [15:0]       Addr,
  input  logic              RD,
  input  logic              WR,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  input  logic              LdEn,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [DATA_W-1:0] LdData,
  output logic              RangeErr,
  output logic              Collision,
  output logic              BurstDone,
  output logic [15:0]       RdCount,
  output logic [15:0]       WrCount
`ifdef MEM_WRPROT_EN
  ,
  input  logic [15:0]       WpBase,
  input  logic [15:0]       WpLimit,
  output logic              WpErr
`endif
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  memState_t         state;
  memState_t         stateNext;
  logic              inRange;
  logic              rdSvc;
  logic              wrSvc;
  logic              wpHit;
  logic              memWr;
  logic              rangeNext;
  logic              collNext;
  logic [ADDR_W-1:0] wordIdx;

  assign inRange = ((Addr >> ADDR_W) == 16'd0);
  assign wordIdx = Addr[ADDR_W-1:0];

`ifdef MEM_WRPROT_EN
  assign wpHit = (Addr >= WpBase) && (Addr <= WpLimit);
`else
  assign wpHit = 1'b0;
`endif

  // A protected write is still a serviced write; only the array update is suppressed.
  assign memWr = wrSvc & ~wpHit;

  // Request decode and next state; a preload cycle freezes the bus side.
  always_comb begin
    stateNext = state;
    rdSvc     = 1'b0;
    wrSvc     = 1'b0;
    rangeNext = 1'b0;
    collNext  = 1'b0;
    if (LdEn) begin
      stateNext = state;
    end else begin
      rangeNext = (RD | WR) & ~inRange;
      collNext  = RD & WR;
      if (WR && inRange) begin
        wrSvc     = 1'b1;
        stateNext = WRITE;
      end else if (RD && inRange) begin
        rdSvc     = 1'b1;
        stateNext = READ;
      end else begin
        stateNext = IDLE;
      end
    end
  end

  // State register.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      if (LdEn) begin
        mem[LdAddr] <= LdData;
      end else if (memWr) begin
        mem[wordIdx] <= DataIn;
      end
    end
  end

  // Registered read data, flag pulses and saturating counters.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      DataOut   <= '0;
      RangeErr  <= 1'b0;
      Collision <= 1'b0;
      RdCount   <= 16'd0;
      WrCount   <= 16'd0;
    end else begin
      RangeErr  <= rangeNext;
      Collision <= collNext;
      if (rdSvc) begin
        DataOut <= mem[wordIdx];
      end else if (!LdEn && RD && !WR && !inRange) begin
        DataOut <= '0;
      end
      if (rdSvc && (RdCount != 16'hFFFF)) begin
        RdCount <= RdCount + 16'd1;
      end
      if (wrSvc && (WrCount != 16'hFFFF)) begin
        WrCount <= WrCount + 16'd1;
      end
    end
  end

`ifdef MEM_WRPROT_EN
  // Write-protect violation pulse.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      WpErr <= 1'b0;
    end else begin
      WpErr <= wrSvc & wpHit;
    end
  end
`endif

  burst_tracker #(
    .BURST_LEN (BURST_LEN)
  ) uBurst (
    .Clk1      (Clk1),
    .Reset     (Reset),
    .Hold      (LdEn),
    .Access    (rdSvc | wrSvc),
    .AccType   (stateNext),
    .Addr      (Addr),
    .BurstDone (BurstDone)
  );

endmodule

// File: tb/tb_sys_mem_resp.sv
// Randomized self-checking bench for sys_mem_resp against a behavioural model.
// Define MEM_WRPROT_EN to also exercise the write-protect window.
module tb_sys_mem_resp;

  localparam int ADDR_W = 10;
  localparam int MEMSZ  = 1 << ADDR_W;
  localparam int BLEN   = 16;
`ifdef MEM_WRPROT_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic              Clk1 = 1'b0;
  logic              Reset;
  logic [15:0]       Addr;
  logic              RD;
  logic              WR;
  logic [15:0]       DataIn;
  logic [15:0]       DataOut;
  logic              LdEn;
  logic [ADDR_W-1:0] LdAddr;
  logic [15:0]       LdData;
  logic              RangeErr;
  logic              Collision;
  logic              BurstDone;
  logic [15:0]       RdCount;
  logic [15:0]       WrCount;
  logic [15:0]       wpBase  = 16'hFFFF;
  logic [15:0]       wpLimit = 16'h0000;
`ifdef MEM_WRPROT_EN
  logic              WpErr;
`endif

  sys_mem_resp #(.ADDR_W(ADDR_W), .BURST_LEN(BLEN)) dut (
    .Clk1      (Clk1),
    .Reset     (Reset),
    .Addr      (Addr),
    .RD        (RD),
    .WR        (WR),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .LdEn      (LdEn),
    .LdAddr    (LdAddr),
    .LdData    (LdData),
    .RangeErr  (RangeErr),
    .Collision (Collision),
    .BurstDone (BurstDone),
    .RdCount   (RdCount),
    .WrCount   (WrCount)
`ifdef MEM_WRPROT_EN
    ,
    .WpBase    (wpBase),
    .WpLimit   (wpLimit),
    .WpErr     (WpErr)
`endif
  );

  always #5 Clk1 = ~Clk1;

  // Reference model state: contents, run length of the current sequence, counts.
  logic [15:0] mdl [MEMSZ];
  int          runLen   = 0;
  int          prevKind = 0;
  logic [15:0] prevAddr = 16'd0;
  int          rdCnt    = 0;
  int          wrCnt    = 0;
  logic [15:0] expDout  = 16'd0;
  logic        expRange, expColl, expDone, expWp;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic doCycle(input logic rst, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] din,
                         input logic ld, input logic [ADDR_W-1:0] la, input logic [15:0] ldat);
    int kind;
    bit inR;
    Reset = rst; RD = rd; WR = wr; Addr = a; DataIn = din;
    LdEn = ld; LdAddr = la; LdData = ldat;
    expRange = 1'b0; expColl = 1'b0; expDone = 1'b0; expWp = 1'b0;
    if (rst) begin
      expDout = 16'd0; rdCnt = 0; wrCnt = 0; runLen = 0; prevKind = 0;
    end else if (ld) begin
      mdl[la] = ldat;
    end else begin
      inR  = (a < MEMSZ);
      kind = wr ? 2 : (rd ? 1 : 0);
      expColl  = rd && wr;
      expRange = (kind != 0) && !inR;
      if ((kind != 0) && inR) begin
        if (kind == 2) begin
          if (WP_ON && a >= wpBase && a <= wpLimit) expWp = 1'b1;
          else mdl[a] = din;
          wrCnt = (wrCnt < 65535) ? wrCnt + 1 : wrCnt;
        end else begin
          expDout = mdl[a];
          rdCnt = (rdCnt < 65535) ? rdCnt + 1 : rdCnt;
        end
        if (kind == prevKind && a == 16'(prevAddr + 16'd1)) runLen++;
        else runLen = 1;
        expDone  = (runLen % BLEN) == 0;
        prevKind = kind;
        prevAddr = a;
      end else begin
        if (kind == 1) expDout = 16'd0;
        runLen = 0;
        prevKind = 0;
      end
    end
    @(posedge Clk1);
    #1;
    check("DataOut", DataOut, expDout);
    check("RangeErr", 16'(RangeErr), 16'(expRange));
    check("Collision", 16'(Collision), 16'(expColl));
    check("BurstDone", 16'(BurstDone), 16'(expDone));
    check("RdCount", RdCount, 16'(rdCnt));
    check("WrCount", WrCount, 16'(wrCnt));
`ifdef MEM_WRPROT_EN
    check("WpErr", 16'(WpErr), 16'(expWp));
`endif
  endtask

  initial begin
    logic        rd, wr, ld;
    logic [15:0] a;
    int          r;
    rd = 1'b0; wr = 1'b0; a = 16'd0;
    doCycle(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, '0, 16'd0);
    doCycle(1'b1, 1'b1, 1'b1, 16'd3, 16'd9, 1'b1, 10'd3, 16'd9);

    for (int i = 0; i < MEMSZ; i++)
      doCycle(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 10'(i), 16'($urandom));

    // Preload then read back.
    doCycle(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 10'd5, 16'h1234);
    doCycle(1'b0, 1'b1, 1'b0, 16'd5, 16'd0, 1'b0, '0, 16'd0);
    check("Read5", DataOut, 16'h1234);

    // Sixteen sequential writes form exactly one burst.
    for (int i = 0; i < 16; i++)
      doCycle(1'b0, 1'b0, 1'b1, 16'h0020 + 16'(i), 16'($urandom), 1'b0, '0, 16'd0);
    check("WrCountBurst", WrCount, 16'd16);

    // Collision: write wins.
    doCycle(1'b0, 1'b1, 1'b1, 16'd7, 16'hBEEF, 1'b0, '0, 16'd0);
    doCycle(1'b0, 1'b1, 1'b0, 16'd7, 16'd0, 1'b0, '0, 16'd0);
    check("Read7", DataOut, 16'hBEEF);

    // First out-of-range address.
    doCycle(1'b0, 1'b1, 1'b0, 16'h0400, 16'd0, 1'b0, '0, 16'd0);
    doCycle(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h5555, 1'b0, '0, 16'd0);

    // Preload cycle masks a simultaneous bus access.
    doCycle(1'b0, 1'b1, 1'b1, 16'h0400, 16'h7777, 1'b1, 10'd9, 16'h4321);
    doCycle(1'b0, 1'b1, 1'b0, 16'd9, 16'd0, 1'b0, '0, 16'd0);

    for (int i = 0; i < 4000; i++) begin
      r  = int'($urandom_range(0, 99));
      ld = (r < 3);
      if (r >= 20 && (rd || wr)) begin
        a = a + 16'd1;
      end else begin
        rd = 1'($urandom_range(0, 1));
        wr = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 9))
          0:       a = 16'($urandom);
          1:       a = 16'($urandom_range(1018, 1030));
          default: a = 16'($urandom_range(0, MEMSZ - 1));
        endcase
      end
      doCycle(1'b0, rd, wr, a, 16'($urandom), ld, 10'($urandom), 16'($urandom));
    end

    // Reset mid-burst abandons the run; array contents survive.
    for (int i = 0; i < 8; i++)
      doCycle(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i), 16'd0, 1'b0, '0, 16'd0);
    doCycle(1'b1, 1'b1, 1'b0, 16'h0108, 16'd0, 1'b0, '0, 16'd0);
    check("RstRdCount", RdCount, 16'd0);
    doCycle(1'b0, 1'b1, 1'b0, 16'h0007, 16'd0, 1'b0, '0, 16'd0);

`ifdef MEM_WRPROT_EN
    wpBase = 16'h0000; wpLimit = 16'h00FF;
    doCycle(1'b0, 1'b0, 1'b1, 16'h0010, 16'hAAAA, 1'b0, '0, 16'd0);
    check("WpErrPulse", 16'(WpErr), 16'd1);
    doCycle(1'b0, 1'b1, 1'b0, 16'h0010, 16'd0, 1'b0, '0, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_mem_resp.md
SYS_MEM_RESP -- requirements
Module: sys_mem_resp

Interface
REQ-001 Parameter ADDR_W, default 10, number of word-address bits implemented; the array holds 2^ADDR_W 16-bit words.
REQ-002 Parameter BURST_LEN, default 16, number of consecutive accesses that forms one vector burst.
REQ-003 Clk1  input  1  clock; all state updates on posedge.
REQ-004 Reset  input  1  reset, synchronous, active-high, sampled on Clk1.
REQ-005 Addr  input  16  word address from the processor.
REQ-006 RD  input  1  read request from the processor.
REQ-007 WR  input  1  write request from the processor.
REQ-008 DataIn  input  16  write data from the processor's DataOut.
REQ-009 DataOut  output  16  read data to the processor's DataIn.
REQ-010 LdEn, LdAddr[ADDR_W-1:0], LdData[15:0]  input  1/ADDR_W/16  testbench preload port.
REQ-011 RangeErr  output  1  one-cycle pulse: out-of-range access.
REQ-012 Collision  output  1  one-cycle pulse: RD and WR high together.
REQ-013 BurstDone  output  1  one-cycle pulse: BURST_LEN consecutive same-type accesses completed.
REQ-014 RdCount, WrCount  output  16 each  saturating counts of serviced reads and writes.

Function
REQ-015 Read: RD=1, WR=0, in range -> DataOut <= mem[Addr] at that edge (latency 1 Clk1); DataOut holds until the next serviced read.
REQ-016 Write: WR=1, in range -> mem[Addr] <= DataIn at that edge; DataOut unchanged.
REQ-017 RD=1 and WR=1 together -> write performed, no read, Collision pulses.
REQ-018 Out of range: Addr[15:ADDR_W] != 0 -> reads return 16'h0000, writes dropped, RangeErr pulses, counters not incremented.
REQ-019 LdEn=1 -> mem[LdAddr] <= LdData; the bus access that cycle is ignored (no data, flags, counters or state change).
REQ-020 State machine: IDLE, READ, WRITE; a serviced read -> READ, a serviced write -> WRITE, no request -> IDLE.
REQ-021 Burst counter (4 bits at default): loads 1 on a serviced access that starts a new sequence; increments when the access is the same type as the previous one and Addr = previous Addr + 1.
REQ-022 Counter reaching BURST_LEN -> BurstDone pulses at that edge and the counter returns to 0.
REQ-023 Idle cycle, type change, or non-sequential address -> the counter restarts at 1 for that access, or at 0 when idle.
REQ-024 Previous-address register wraps modulo 2^16; a sequence crossing 16'hFFFF->0 counts as consecutive.
REQ-025 RdCount/WrCount increment by 1 per serviced access and saturate at 16'hFFFF.

Reset
REQ-026 Reset -> state IDLE, burst counter 0, DataOut 0, RangeErr/Collision/BurstDone 0, RdCount/WrCount 0.
REQ-027 Array contents are not cleared by reset.
REQ-028 Reset wins over any simultaneous request or load; a burst in progress is abandoned without a BurstDone pulse.

Configuration
REQ-029 Macro MEM_WRPROT_EN defined -> extra inputs WpBase[15:0] and WpLimit[15:0] and output WpErr (1).
REQ-030 With MEM_WRPROT_EN, bus writes with WpBase <= Addr <= WpLimit are dropped and WpErr pulses; WrCount and the burst counter still advance; the preload port is unaffected.
REQ-031 Without MEM_WRPROT_EN, these ports are absent and every in-range write is performed.

Structure
REQ-032 Package mem_resp_pkg holds the state enum (IDLE/READ/WRITE), the data-width constant 16, and the default BURST_LEN.
REQ-033 Sub-module burst_tracker holds the previous address, previous type, burst counter and BurstDone logic.
REQ-034 The array is a single inferred synchronous-write, registered-read memory.

Verification
REQ-035 Preload mem[5]=16'h1234; RD=1, Addr=5 -> DataOut=16'h1234 one edge later; RdCount=1.
REQ-036 16 writes to Addr 16'h0020..16'h002F on consecutive cycles -> BurstDone pulses on the 16th only; WrCount=16.
REQ-037 RD=WR=1, Addr=7, DataIn=16'hBEEF -> Collision pulses; a later read of 7 returns 16'hBEEF.
REQ-038 Read at Addr 16'h0400 (ADDR_W=10) -> DataOut=0, RangeErr pulses, RdCount unchanged.
REQ-039 Reset asserted after 8 burst reads -> no BurstDone; all outputs and counters 0; preloaded data intact.
REQ-040 With MEM_WRPROT_EN, WpBase=0, WpLimit=16'h00FF, write 16'hAAAA to Addr 16'h0010 -> WpErr pulses; mem[16'h0010] unchanged.
